// File: rtl/core_ex_lsu_if.sv
// Data-bus interface between the core_ex_lsu load/store unit (master) and memory (slave).
interface core_ex_lsu_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned STRB_W = XLEN / 8;

  logic              mem_req_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [STRB_W-1:0] mem_strb_out;
  logic [XLEN-1:0]   mem_data_out;
  logic [XLEN-1:0]   mem_data_in;
  logic              mem_ack_in;

  modport master (
    output mem_req_out, mem_we_out, mem_addr_out, mem_strb_out, mem_data_out,
    input  mem_data_in, mem_ack_in
  );

  modport slave (
    input  mem_req_out, mem_we_out, mem_addr_out, mem_strb_out, mem_data_out,
    output mem_data_in, mem_ack_in
  );
endinterface

// File: rtl/core_ex_lsu.sv
// Registered execute stage: ALU writeback, jumps/branches and a handshaked load/store unit.
// Optional macro CORE_EX_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of aligning them.
module core_ex_lsu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        func3_in,
  input  logic              reg_we_in,
  input  logic [4:0]        reg_write_addr_in,
  input  logic [XLEN-1:0]   reg1_data_in,
  input  logic [XLEN-1:0]   reg2_data_in,
  input  logic [XLEN-1:0]   eval_val_in,
  input  logic [ADDR_W-1:0] inst_addr_in,
  input  logic [XLEN-1:0]   immI_in,
  input  logic [XLEN-1:0]   immB_in,
  input  logic [XLEN-1:0]   immJ_in,
  output logic              reg_we_out,
  output logic [4:0]        reg_write_addr_out,
  output logic [XLEN-1:0]   reg_write_data_out,
  output logic              hold_flag_out,
  output logic              jump_flag_out,
  output logic [ADDR_W-1:0] jump_addr_out,
  core_ex_lsu_if.master     bus,
  output logic              bus_err_out,
  output logic              misalign_out
);
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] CPU_RST_ADDRESS = '0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Branch compare code carried on eval_val_in: one flag bit per relation.
  localparam int unsigned CMP_EQ_BIT  = 0;
  localparam int unsigned CMP_LT_BIT  = 1;
  localparam int unsigned CMP_LTU_BIT = 2;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [OFF_W-1:0] lane_q;
  logic [2:0]       func3_q;
  logic [4:0]       rd_q;
  logic             wb_en_q;

  logic              is_mem_c, is_store_c, trap_c, take_c, timeout_c;
  logic [ADDR_W-1:0] eff_addr_c;
  logic [OFF_W-1:0]  off_c, lane_off_c;
  logic [1:0]        size_c;
  logic [7:0]        size_mask_c;
  logic [STRB_W-1:0] strb_c;
  logic [XLEN-1:0]   wdata_c, rdata_sh_c, load_data_c;

  // Accept-side decode: address, lane, strobes, replicated store data, branch outcome.
  always_comb begin
    is_mem_c    = (opcode_in == OP_LOAD) || (opcode_in == OP_STORE);
    is_store_c  = (opcode_in == OP_STORE);
    eff_addr_c  = ADDR_W'(eval_val_in);
    off_c       = eff_addr_c[OFF_W-1:0];
    size_c      = func3_in[1:0];
    lane_off_c  = off_c & ~OFF_W'((32'd1 << size_c) - 32'd1);
    size_mask_c = 8'hFF;
    wdata_c     = reg2_data_in;
    case (size_c)
      2'd0: begin
        size_mask_c = 8'h01;
        wdata_c     = {STRB_W{reg2_data_in[7:0]}};
      end
      2'd1: begin
        size_mask_c = 8'h03;
        wdata_c     = {(STRB_W/2){reg2_data_in[15:0]}};
      end
      2'd2: begin
        size_mask_c = 8'h0F;
        wdata_c     = {(XLEN/32){reg2_data_in[31:0]}};
      end
      default: ;
    endcase
    strb_c = is_store_c ? (STRB_W'(size_mask_c) << lane_off_c) : '1;
    take_c = 1'b0;
    case (func3_in)
      3'd0: take_c =  eval_val_in[CMP_EQ_BIT];
      3'd1: take_c = !eval_val_in[CMP_EQ_BIT];
      3'd4: take_c =  eval_val_in[CMP_LT_BIT];
      3'd5: take_c = !eval_val_in[CMP_LT_BIT];
      3'd6: take_c =  eval_val_in[CMP_LTU_BIT];
      3'd7: take_c = !eval_val_in[CMP_LTU_BIT];
      default: take_c = 1'b0;
    endcase
  end

  // Load return: select the lane captured at acceptance and extend.
  always_comb begin
    rdata_sh_c = bus.mem_data_in >> {lane_q, 3'b000};
    case (func3_q)
      3'd0:    load_data_c = XLEN'($signed(rdata_sh_c[7:0]));
      3'd1:    load_data_c = XLEN'($signed(rdata_sh_c[15:0]));
      3'd2:    load_data_c = XLEN'($signed(rdata_sh_c[31:0]));
      3'd4:    load_data_c = XLEN'(rdata_sh_c[7:0]);
      3'd5:    load_data_c = XLEN'(rdata_sh_c[15:0]);
      3'd6:    load_data_c = XLEN'(rdata_sh_c[31:0]);
      default: load_data_c = rdata_sh_c;
    endcase
  end

  assign timeout_c = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef CORE_EX_MISALIGN_TRAP_EN
  logic misaligned_c;
  assign misaligned_c = ((size_c == 2'd1) && off_c[0]) || ((size_c == 2'd2) && (off_c[1:0] != 2'b00));
  assign trap_c       = is_mem_c && misaligned_c;

  always_ff @(posedge clk) begin
    if (rst) misalign_out <= 1'b0;
    else     misalign_out <= (state == S_IDLE) && valid_in && trap_c;
  end
`else
  assign trap_c       = 1'b0;
  assign misalign_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      cnt                <= '0;
      lane_q             <= '0;
      func3_q            <= '0;
      rd_q               <= '0;
      wb_en_q            <= 1'b0;
      reg_we_out         <= 1'b0;
      reg_write_addr_out <= '0;
      reg_write_data_out <= '0;
      hold_flag_out      <= 1'b0;
      jump_flag_out      <= 1'b0;
      jump_addr_out      <= CPU_RST_ADDRESS;
      bus_err_out        <= 1'b0;
      bus.mem_req_out    <= 1'b0;
      bus.mem_we_out     <= 1'b0;
      bus.mem_addr_out   <= CPU_RST_ADDRESS;
      bus.mem_strb_out   <= '0;
      bus.mem_data_out   <= '0;
    end else begin
      reg_we_out    <= 1'b0;
      jump_flag_out <= 1'b0;
      bus_err_out   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_in && is_mem_c) begin
            if (!trap_c) begin
              state            <= S_MEM;
              hold_flag_out    <= 1'b1;
              cnt              <= '0;
              lane_q           <= lane_off_c;
              func3_q          <= func3_in;
              rd_q             <= reg_write_addr_in;
              wb_en_q          <= reg_we_in && (reg_write_addr_in != 5'd0);
              bus.mem_req_out  <= 1'b1;
              bus.mem_we_out   <= is_store_c;
              bus.mem_addr_out <= {eff_addr_c[ADDR_W-1:OFF_W], OFF_W'(0)};
              bus.mem_strb_out <= strb_c;
              bus.mem_data_out <= wdata_c;
            end
          end else if (valid_in) begin
            reg_we_out         <= reg_we_in && (reg_write_addr_in != 5'd0);
            reg_write_addr_out <= reg_write_addr_in;
            reg_write_data_out <= eval_val_in;
            if (opcode_in == OP_JAL) begin
              jump_flag_out <= 1'b1;
              jump_addr_out <= inst_addr_in + ADDR_W'(immJ_in);
            end else if (opcode_in == OP_JALR) begin
              jump_flag_out <= 1'b1;
              jump_addr_out <= ADDR_W'(reg1_data_in + immI_in) & ~ADDR_W'(1);
            end else if ((opcode_in == OP_BRANCH) && take_c) begin
              jump_flag_out <= 1'b1;
              jump_addr_out <= inst_addr_in + ADDR_W'(immB_in);
            end
          end
        end
        S_MEM: begin
          // Ack beats a timeout landing in the same cycle.
          if (bus.mem_ack_in) begin
            bus.mem_req_out <= 1'b0;
            if (bus.mem_we_out) begin
              state         <= S_IDLE;
              hold_flag_out <= 1'b0;
            end else begin
              state              <= S_WB;
              reg_we_out         <= wb_en_q;
              reg_write_addr_out <= rd_q;
              reg_write_data_out <= load_data_c;
            end
          end else if (timeout_c) begin
            bus.mem_req_out <= 1'b0;
            bus_err_out     <= 1'b1;
            state           <= S_IDLE;
            hold_flag_out   <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          state         <= S_IDLE;
          hold_flag_out <= 1'b0;
        end
        default: begin
          state         <= S_IDLE;
          hold_flag_out <= 1'b0;
        end
      endcase
    end
  end
endmodule
